gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4.sv | 147 ++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4.sv
// NOR4 all-low deglitch stage: registered flag Q follows ~(A1|A2|A3|A4) only after
// FILT_LEN persistent samples, with a one-cycle pulse QP on each Q rise.

module gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4_func #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 3
) (
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic notifier,
  output logic Q,
  output logic QP,
  inout  logic VDD,
  inout  logic VSS
);

  if ((FILT_LEN < 2) || (FILT_LEN > 8)) begin : g_bad_filt_len
    $error("FILT_LEN must lie in 2..8");
  end
  if ((1 << CNT_W) < FILT_LEN) begin : g_bad_cnt_w
    $error("CNT_W too narrow for FILT_LEN");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             notifier_q;
  logic             zn;
  logic             viol;
  logic             unused_pwr;

  assign zn         = ~(A1 | A2 | A3 | A4);
  assign viol       = notifier ^ notifier_q;
  assign unused_pwr = VDD ^ VSS;

  // Any notifier toggle between edges marks the next sample as unknown.
  always_ff @(posedge CLK) begin
    notifier_q <= notifier;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s   <= 1'b0;
      cnt <= '0;
      Q   <= 1'b0;
      QP  <= 1'b0;
    end else begin
      if (viol) begin
        s <= 1'bx;
      end else begin
        s <= zn;
      end
      QP <= 1'b0;
      // An unknown sample falls through both tests, so Q and cnt hold.
      if ((s == 1'b1) || (s == 1'b0)) begin
        if (s != Q) begin
          if (cnt == CNT_MAX) begin
            Q   <= s;
            QP  <= s;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

module gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4 #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 3
) (
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  output logic Q,
  output logic QP,
  inout  logic VDD,
  inout  logic VSS
);

`ifdef TIMING
  logic notifier;

  gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4_func #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (CNT_W)
  ) u_func (
    .CLK     (CLK),
    .RN      (RN),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .A4      (A4),
    .notifier(notifier),
    .Q       (Q),
    .QP      (QP),
    .VDD     (VDD),
    .VSS     (VSS)
  );

  specify
    (posedge CLK => Q)  = (1.0, 1.0);
    (posedge CLK => QP) = (1.0, 1.0);
    (negedge RN => Q)   = (1.0, 1.0);
    (negedge RN => QP)  = (1.0, 1.0);
    $setuphold(posedge CLK, A1, 0.0, 0.0, notifier);
    $setuphold(posedge CLK, A2, 0.0, 0.0, notifier);
    $setuphold(posedge CLK, A3, 0.0, 0.0, notifier);
    $setuphold(posedge CLK, A4, 0.0, 0.0, notifier);
    $width(posedge CLK, 1.0, 0, notifier);
    $width(negedge CLK, 1.0, 0, notifier);
    $width(negedge RN, 1.0, 0, notifier);
    $recrem(posedge RN, posedge CLK, 0.0, 0.0, notifier);
  endspecify
`else
  gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4_func #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (CNT_W)
  ) u_func (
    .CLK     (CLK),
    .RN      (RN),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .A4      (A4),
    .notifier(1'b0),
    .Q       (Q),
    .QP      (QP),
    .VDD     (VDD),
    .VSS     (VSS)
  );
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4.sv
// Bench for the NOR4 deglitch stage at FILT_LEN 2, 4 and 8 side by side, checked
// against a sliding-window model of the sampled NOR4 history.

module tb_gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4;

  logic       clk = 1'b0;
  logic       rn;
  logic       a1, a2, a3, a4;
  logic [2:0] q;
  logic [2:0] qp;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int checks   = 0;
  int failures = 0;

  localparam int LEN [3] = '{2, 4, 8};

  // smp holds the NOR4 value sampled at each edge since reset, oldest first.
  bit smp [$];
  bit qm  [3];
  bit qpm [3];

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4 #(.FILT_LEN(2), .CNT_W(3)) u_dut2 (
    .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .A3(a3), .A4(a4),
    .Q(q[0]), .QP(qp[0]), .VDD(vdd), .VSS(vss)
  );
  gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4 #(.FILT_LEN(4), .CNT_W(3)) u_dut4 (
    .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .A3(a3), .A4(a4),
    .Q(q[1]), .QP(qp[1]), .VDD(vdd), .VSS(vss)
  );
  gf180mcu_fd_sc_mcu7t5v0__nor4_filt_4 #(.FILT_LEN(8), .CNT_W(3)) u_dut8 (
    .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .A3(a3), .A4(a4),
    .Q(q[2]), .QP(qp[2]), .VDD(vdd), .VSS(vss)
  );

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s L=%0d observed=%b expected=%b t=%0t", tag, LEN[k], obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back(1'b0);
    for (int k = 0; k < 3; k++) begin
      qm[k]  = 1'b0;
      qpm[k] = 1'b0;
    end
  endtask

  // Q changes at an edge exactly when the last LEN samples agree and differ from Q.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit v;
      bit same;
      v    = smp[smp.size() - 1];
      same = 1'b1;
      for (int j = 1; j <= LEN[k]; j++)
        if (smp[smp.size() - j] != v) same = 1'b0;
      qpm[k] = 1'b0;
      if (same && (v != qm[k])) begin
        qm[k]  = v;
        qpm[k] = v;
      end
    end
    smp.push_back(bit'(~(a1 | a2 | a3 | a4)));
    if (smp.size() > 16) void'(smp.pop_front());
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    for (int k = 0; k < 3; k++) begin
      check({tag, "_q"}, k, q[k], qm[k]);
      check({tag, "_qp"}, k, qp[k], qpm[k]);
    end
  endtask

  task automatic tick_n(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rn = 1'b0;
    {a1, a2, a3, a4} = 4'b0000;
    model_reset();

    #12;
    for (int k = 0; k < 3; k++) begin
      check("reset_q", k, q[k], 1'b0);
      check("reset_qp", k, qp[k], 1'b0);
    end
    rn = 1'b1;

    tick_n("rise", 10);

    a2 = 1'b1;
    tick_n("glitch3", 3);
    a2 = 1'b0;
    tick_n("glitch3_after", 10);

    a3 = 1'b1;
    tick_n("fall", 10);
    a3 = 1'b0;
    tick_n("pend", 2);

    #3;
    rn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("midreset_q", k, q[k], 1'b0);
      check("midreset_qp", k, qp[k], 1'b0);
    end
    model_reset();
    #3;
    rn = 1'b1;
    tick_n("rerise", 10);

    a1 = 1'b1;
    tick_n("glitch7", 7);
    a1 = 1'b0;
    tick_n("glitch7_after", 10);

    rn = 1'b0;
    #2;
    rn = 1'b1;
    a1 = 1'bx;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        check("xin_q", k, q[k], 1'b0);
        check("xin_qp", k, qp[k], 1'b0);
      end
    end
    a4 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k < 3; k++) begin
      check("xforce_q", k, q[k], 1'b0);
      check("xforce_qp", k, qp[k], 1'b0);
    end
    {a1, a2, a3, a4} = 4'b0000;
    rn = 1'b0;
    #1;
    model_reset();
    #1;
    rn = 1'b1;
    tick_n("resume", 10);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) {a1, a2, a3, a4} = 4'b0000;
        else {a1, a2, a3, a4} = 4'($urandom_range(15));
      end
      if ($urandom_range(99) == 0) begin
        #2;
        rn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check("rand_reset_q", k, q[k], 1'b0);
        model_reset();
        #1;
        rn = 1'b1;
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
